exmem_skid: RTL and testbench
=============================

Name: exmem_skid

Overview:
- Two-entry skid buffer forming the execute→memory pipeline register.
- Captures a completed ALU result, with the instruction's PC, store data, destination register and control bits, when execute reports a valid, non-bubbled instruction.
- Presents the captured entries to the memory stage under a valid/ready handshake.
- Absorbs one cycle of downstream back-pressure without a combinational ready path from memory back to the ALU/multiplier/divider.

Parameters:
- CTRL_W, 8, width of the opaque memory/writeback control field (regwrite, memread, memwrite, size, unsigned, ...).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_valid  input  1  execute holds a finished instruction (valid and ALU bubble low).
- in_ready  output  1  buffer accepts an entry this cycle; registered, equals "skid slot empty".
- in_pc  input  64  instruction PC.
- in_result  input  64  ALU result (already sign-extended for word ops).
- in_wdata  input  64  store data.
- in_rd  input  5  destination register index.
- in_ctrl  input  CTRL_W  control bits, passed through unmodified.
- flush  input  1  synchronous kill of all buffered and incoming entries.
- out_valid  output  1  main slot holds an entry.
- out_ready  input  1  memory stage consumes the main slot this cycle.
- out_pc, out_result, out_wdata, out_rd, out_ctrl  output  64/64/64/5/CTRL_W  fields of the main slot.
- occ  output  2  number of valid entries (0..2).

Behaviour:
- Storage: main slot M (drives out_*) and skid slot S, each with a valid bit. Payload = {pc, result, wdata, rd, ctrl}.
- Handshake terms:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
  - in_ready = ~S.valid, registered; it never depends on out_ready combinationally.
- Reset (resetn low, asynchronous):
  - M.valid = S.valid = 0; in_ready = 1; occ = 0.
  - All out_* payload registers = 0.
  - Reset released mid-stream discards all entries.
- State EMPTY (occ = 0):
  - accept → M loads input; go ONE.
  - out_valid is 0, so out_ready is ignored.
  - Latency input→output is 1 cycle; no combinational bypass.
- State ONE (occ = 1):
  - consume & accept → M loads input; stay ONE. Full throughput, one per cycle.
  - consume & ~accept → M.valid = 0; go EMPTY.
  - ~consume & accept → S loads input; go TWO; in_ready falls next cycle.
  - neither → hold.
- State TWO (occ = 2):
  - in_ready = 0, so no accept is possible.
  - consume → M loads S, S.valid = 0; go ONE; in_ready rises next cycle.
  - ~consume → hold all payload stable.
- Order: entries leave in arrival order. S is never presented before M.
- Payload stability: while out_valid & ~out_ready, out_* must not change.
- Flush has priority over every other event that cycle:
  - Next cycle M.valid = S.valid = 0, occ = 0, in_ready = 1.
  - Any same-cycle accept is dropped.
  - A same-cycle consume still counts as consumed; the memory stage decides whether to honour it.
  - Payload registers may keep stale values, but out_valid must be 0.
- in_valid while in_ready = 0: ignored; execute must hold the instruction (its stall logic uses in_ready).
- occ is always M.valid + S.valid; the combination S.valid & ~M.valid is unreachable, and an assertion must flag it.
- in_ctrl is never interpreted; any bit pattern passes through unchanged.

Test Plan:
1. Reset passthrough: resetn low then high; in_valid=1, pc=0x80000000, result=0x5, rd=3, out_ready=1 → next cycle out_valid=1, out_result=0x5, out_rd=3, occ=1; after the input drops, occ=0.
2. Streaming: 8 back-to-back inputs with result=1..8, out_ready held 1 → outputs 1..8 on consecutive cycles; in_ready stays 1; occ never exceeds 1.
3. Skid: hold out_ready=0 and push A=0x11, then B=0x22 → occ=2, in_ready=0 on the cycle after B. With out_ready=1 → A, then B, in order; in_ready returns to 1 the cycle after A leaves.
4. Stall hold: occ=2 with in_valid=1 for C=0x33 for 3 cycles → C not accepted; out_result stays 0x11 and payload bits are unchanged while stalled.
5. Flush at occ=2 with simultaneous in_valid=1 (D=0x44) → next cycle out_valid=0, occ=0, in_ready=1; D never appears at the output.
6. Async reset mid-stream: assert resetn low between clock edges at occ=2 → out_valid and occ go to 0 immediately, without waiting for a clock edge, and out_result reads 0.

Source files
------------

// File: rtl/exmem_skid_if.sv
// exmem_skid_if: execute->memory handshake bundle (input side, output side, occupancy)
`timescale 1ns/1ps
interface exmem_skid_if #(parameter int CTRL_W = 8);
    logic              in_valid;
    logic              in_ready;
    logic [63:0]       in_pc;
    logic [63:0]       in_result;
    logic [63:0]       in_wdata;
    logic [4:0]        in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_pc;
    logic [63:0]       out_result;
    logic [63:0]       out_wdata;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occ;
    modport slave (
        input  in_valid, in_pc, in_result, in_wdata, in_rd, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_pc, out_result, out_wdata, out_rd, out_ctrl, occ
    );
    modport master (
        output in_valid, in_pc, in_result, in_wdata, in_rd, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_result, out_wdata, out_rd, out_ctrl, occ
    );
endinterface

// File: rtl/exmem_skid.sv
// exmem_skid: two-entry skid buffer acting as the execute->memory pipeline register
`timescale 1ns/1ps
module exmem_skid #(
    parameter int CTRL_W = 8
) (
    input logic        clk,
    input logic        resetn,
    exmem_skid_if.slave bus
);
    localparam int PW = 64 * 3 + 5 + CTRL_W;

    logic          m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [PW-1:0] m_q, m_d, s_q, s_d, in_pl;
    logic          accept, consume;

    assign in_pl   = {bus.in_pc, bus.in_result, bus.in_wdata, bus.in_rd, bus.in_ctrl};
    assign accept  = bus.in_valid & ~s_valid_q;
    assign consume = m_valid_q & bus.out_ready;

    assign bus.in_ready  = ~s_valid_q;
    assign bus.out_valid = m_valid_q;
    assign bus.occ       = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    assign {bus.out_pc, bus.out_result, bus.out_wdata, bus.out_rd, bus.out_ctrl} = m_q;

    // Next state: flush wins; with the skid full only a drain into main can happen,
    // otherwise main refills when empty or consumed, and the skid catches a stalled accept.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (bus.flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            if (consume) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end
        end else if (consume || !m_valid_q) begin
            if (accept) m_d = in_pl;
            m_valid_d = accept;
        end else if (accept) begin
            s_d       = in_pl;
            s_valid_d = 1'b1;
        end
    end

    // Slot registers; reset clears valids and payload so the outputs read zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_q       <= m_d;
            s_q       <= s_d;
        end
    end

    a_no_orphan_skid: assert property (@(posedge clk) disable iff (!resetn) !(s_valid_q && !m_valid_q));
endmodule

// File: tb/tb_exmem_skid.sv
// tb_exmem_skid: directed stimulus with a queue scoreboard checked by an output monitor
`timescale 1ns/1ps
module tb_exmem_skid;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] res;
        logic [63:0] wd;
        logic [4:0]  rd;
        logic [7:0]  ctrl;
    } pl_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    pl_t  exp_q[$];

    exmem_skid_if #(.CTRL_W(8)) bus ();
    exmem_skid #(.CTRL_W(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    function automatic pl_t mk(input logic [63:0] r);
        pl_t p;
        p.pc   = 64'h2000 + (r << 2);
        p.res  = r;
        p.wd   = (r << 8) ^ 64'hdead_beef_0000_0000;
        p.rd   = r[4:0];
        p.ctrl = r[7:0] ^ 8'h5a;
        return p;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic v, input pl_t p);
        bus.in_valid  = v;
        bus.in_pc     = p.pc;
        bus.in_result = p.res;
        bus.in_wdata  = p.wd;
        bus.in_rd     = p.rd;
        bus.in_ctrl   = p.ctrl;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every presented-and-consumed entry must match the oldest expected one.
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready) begin
            pl_t got;
            pl_t e;
            got = {bus.out_pc, bus.out_result, bus.out_wdata, bus.out_rd, bus.out_ctrl};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got result %h expected no output", got.res);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL out_payload: got pc %h res %h wd %h rd %0d ctrl %h expected pc %h res %h wd %h rd %0d ctrl %h",
                             got.pc, got.res, got.wd, got.rd, got.ctrl, e.pc, e.res, e.wd, e.rd, e.ctrl);
                end
            end
        end
    end

    initial begin
        pl_t p;
        drive(1'b0, '0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_occ", {62'd0, bus.occ}, 64'd0);
        chk("rst_out_result", bus.out_result, 64'd0);

        // 1: passthrough after reset release
        #21;
        resetn = 1'b1;
        p = '{pc: 64'h8000_0000, res: 64'h5, wd: 64'h0, rd: 5'd3, ctrl: 8'h00};
        drive(1'b1, p);
        bus.out_ready = 1'b1;
        exp_q.push_back(p);
        step();
        drive(1'b0, '0);
        chk("t1_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t1_out_result", bus.out_result, 64'h5);
        chk("t1_out_rd", {59'd0, bus.out_rd}, 64'd3);
        chk("t1_occ", {62'd0, bus.occ}, 64'd1);
        step();
        chk("t1_occ_drain", {62'd0, bus.occ}, 64'd0);

        // 2: streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            p = mk(64'(i));
            drive(1'b1, p);
            exp_q.push_back(p);
            step();
            chk("t2_in_ready", {63'd0, bus.in_ready}, 64'd1);
            chk("t2_occ", {62'd0, bus.occ}, 64'd1);
            chk("t2_out_result", bus.out_result, 64'(i));
        end
        drive(1'b0, '0);
        step();
        chk("t2_occ_end", {62'd0, bus.occ}, 64'd0);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: skid absorbs one entry under back-pressure
        bus.out_ready = 1'b0;
        p = mk(64'h11);
        drive(1'b1, p);
        exp_q.push_back(p);
        step();
        chk("t3_occ_a", {62'd0, bus.occ}, 64'd1);
        chk("t3_in_ready_a", {63'd0, bus.in_ready}, 64'd1);
        p = mk(64'h22);
        drive(1'b1, p);
        exp_q.push_back(p);
        step();
        chk("t3_occ_b", {62'd0, bus.occ}, 64'd2);
        chk("t3_in_ready_b", {63'd0, bus.in_ready}, 64'd0);

        // 4: full and stalled, C must be refused and payload held
        drive(1'b1, mk(64'h33));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_occ", {62'd0, bus.occ}, 64'd2);
            chk("t4_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("t4_out_result", bus.out_result, 64'h11);
            chk("t4_out_pc", bus.out_pc, mk(64'h11).pc);
            chk("t4_out_wdata", bus.out_wdata, mk(64'h11).wd);
            chk("t4_out_ctrl", {56'd0, bus.out_ctrl}, {56'd0, mk(64'h11).ctrl});
        end
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        step();
        chk("t3_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
        chk("t3_occ_after_a", {62'd0, bus.occ}, 64'd1);
        chk("t3_out_b", bus.out_result, 64'h22);
        step();
        chk("t3_occ_after_b", {62'd0, bus.occ}, 64'd0);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: flush at occ=2 with a simultaneous input
        bus.out_ready = 1'b0;
        drive(1'b1, mk(64'h55));
        step();
        drive(1'b1, mk(64'h66));
        step();
        chk("t5_occ_full", {62'd0, bus.occ}, 64'd2);
        bus.flush = 1'b1;
        drive(1'b1, mk(64'h44));
        step();
        bus.flush = 1'b0;
        drive(1'b0, '0);
        chk("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_occ", {62'd0, bus.occ}, 64'd0);
        chk("t5_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_d", {63'd0, bus.out_valid}, 64'd0);
        end

        // 6: asynchronous reset between edges at occ=2
        bus.out_ready = 1'b0;
        p = mk(64'h77);
        drive(1'b1, p);
        step();
        drive(1'b1, mk(64'h88));
        step();
        drive(1'b0, '0);
        chk("t6_occ_full", {62'd0, bus.occ}, 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_occ", {62'd0, bus.occ}, 64'd0);
        chk("t6_out_result", bus.out_result, 64'd0);
        chk("t6_in_ready", {63'd0, bus.in_ready}, 64'd1);
        #3;
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        p = mk(64'h99);
        drive(1'b1, p);
        exp_q.push_back(p);
        step();
        drive(1'b0, '0);
        chk("t6_restart_result", bus.out_result, 64'h99);
        step();
        step();
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("final_occ", {62'd0, bus.occ}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
